// File: rtl/itu656_pkg.sv
// itu656_pkg
// Shared constants for the BT.656 525/60 encoder:
//   - horizontal region boundaries (EAV, blanking, SAV, active)
//   - field/vertical-blank line limits and active-line bases
//   - blank, TRS and clip byte values
//   - ctl_t: per-byte control word carried down the output pipeline
//   - xy_code(): TRS status word with protection bits
//   - clip8(): limits an active sample to 0x01..0xFE
package itu656_pkg;

  localparam int unsigned HC_W = 11;
  localparam int unsigned LN_W = 10;

  localparam logic [HC_W-1:0] H_EAV    = 11'd0;
  localparam logic [HC_W-1:0] H_BLANK  = 11'd4;
  localparam logic [HC_W-1:0] H_SAV    = 11'd272;
  localparam logic [HC_W-1:0] H_ACTIVE = 11'd276;

  localparam logic [LN_W-1:0] F0_FIRST = 10'd4;
  localparam logic [LN_W-1:0] F0_LAST  = 10'd265;
  localparam logic [LN_W-1:0] V1_LAST  = 10'd19;
  localparam logic [LN_W-1:0] V2_FIRST = 10'd264;
  localparam logic [LN_W-1:0] V2_LAST  = 10'd282;
  localparam logic [LN_W-1:0] Y0_BASE  = 10'd20;
  localparam logic [LN_W-1:0] Y1_BASE  = 10'd283;

  localparam logic [7:0] BLK_Y   = 8'h10;
  localparam logic [7:0] BLK_C   = 8'h80;
  localparam logic [7:0] CLIP_LO = 8'h01;
  localparam logic [7:0] CLIP_HI = 8'hFE;
  localparam logic [7:0] TRS_FF  = 8'hFF;
  localparam logic [7:0] TRS_00  = 8'h00;

  // Control for one output byte. When vid is set the byte comes from the
  // pixel-pair buffer (phase selects Cb/Y/Cr/Y), otherwise it is 'fixed'.
  typedef struct packed {
    logic       vid;
    logic [1:0] phase;
    logic       cap_even;
    logic       cap_odd;
    logic       sync;
    logic [7:0] fixed;
  } ctl_t;

  localparam ctl_t CTL_IDLE = '{vid: 1'b0, phase: 2'd0, cap_even: 1'b0,
                                cap_odd: 1'b0, sync: 1'b0, fixed: BLK_Y};

  function automatic logic [7:0] xy_code(input logic f, input logic v, input logic h);
    return {1'b1, f, v, h, v ^ h, f ^ h, f ^ v, f ^ v ^ h};
  endfunction

  function automatic logic [7:0] clip8(input logic [7:0] s);
    if (s < CLIP_LO) return CLIP_LO;
    if (s > CLIP_HI) return CLIP_HI;
    return s;
  endfunction

endpackage

// File: rtl/itu656_timing_gen.sv
// itu656_timing_gen
// Horizontal byte counter (Hc) and line counter (1..V_TOTAL), F/V/H flag
// decode and generation of the per-byte control word plus the pixel request
// interface. All outputs are registered and describe the same byte slot.
// Ports:
//   clk_i, rst_ni   byte clock, async active-low reset
//   ctl_o           control word for the current byte slot
//   req_o           pixel request strobe (even active-byte offsets)
//   tv_x_o, tv_y_o  requested column / active line in field (held between requests)
//   field_o         F bit of the current line
module itu656_timing_gen
  import itu656_pkg::*;
#(
  parameter int unsigned H_TOTAL = 1716,
  parameter int unsigned V_TOTAL = 525
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  output ctl_t       ctl_o,
  output logic       req_o,
  output logic [9:0] tv_x_o,
  output logic [9:0] tv_y_o,
  output logic       field_o
);

  localparam logic [HC_W-1:0] HC_LAST = HC_W'(H_TOTAL - 1);
  localparam logic [LN_W-1:0] LN_LAST = LN_W'(V_TOTAL);

  logic [HC_W-1:0] hc_q, hc_d;
  logic [LN_W-1:0] line_q, line_d;
  logic            f, v, is_eav, is_sav, is_act;
  logic [HC_W-1:0] act_ofs;
  ctl_t            ctl_d, ctl_q;
  logic            req_d, req_q;
  logic [9:0]      tv_x_q, tv_y_q, tv_y_d;
  logic            field_q;

  always_comb begin
    hc_d   = hc_q + 11'd1;
    line_d = line_q;
    if (hc_q == HC_LAST) begin
      hc_d   = '0;
      line_d = (line_q == LN_LAST) ? 10'd1 : line_q + 10'd1;
    end
  end

  always_comb begin
    f       = !((line_q >= F0_FIRST) && (line_q <= F0_LAST));
    v       = (line_q <= V1_LAST) || ((line_q >= V2_FIRST) && (line_q <= V2_LAST));
    is_eav  = (hc_q >= H_EAV) && (hc_q < H_BLANK);
    is_sav  = (hc_q >= H_SAV) && (hc_q < H_ACTIVE);
    is_act  = (hc_q >= H_ACTIVE);
    act_ofs = hc_q - H_ACTIVE;
    tv_y_d  = f ? (line_q - Y1_BASE) : (line_q - Y0_BASE);

    ctl_d       = CTL_IDLE;
    // Blanking alternates C/Y starting with C on an even count; 4 and 276 are even.
    ctl_d.fixed = hc_q[0] ? BLK_Y : BLK_C;
    if (is_eav || is_sav) begin
      // EAV and SAV both start on a multiple of 4, so hc[1:0] is the TRS byte index.
      case (hc_q[1:0])
        2'd0: begin
          ctl_d.fixed = TRS_FF;
          ctl_d.sync  = 1'b1;
        end
        2'd3:    ctl_d.fixed = xy_code(f, v, is_eav);
        default: ctl_d.fixed = TRS_00;
      endcase
    end
    if (is_act && !v) begin
      ctl_d.vid      = 1'b1;
      ctl_d.phase    = act_ofs[1:0];
      ctl_d.cap_even = (act_ofs[1:0] == 2'd0);
      ctl_d.cap_odd  = (act_ofs[1:0] == 2'd2);
    end
    req_d = ctl_d.cap_even || ctl_d.cap_odd;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hc_q    <= '0;
      line_q  <= 10'd1;
      ctl_q   <= CTL_IDLE;
      req_q   <= 1'b0;
      tv_x_q  <= '0;
      tv_y_q  <= '0;
      field_q <= 1'b0;
    end else begin
      hc_q    <= hc_d;
      line_q  <= line_d;
      ctl_q   <= ctl_d;
      req_q   <= req_d;
      field_q <= f;
      if (req_d) begin
        tv_x_q <= act_ofs[10:1];
        tv_y_q <= tv_y_d;
      end
    end
  end

  assign ctl_o   = ctl_q;
  assign req_o   = req_q;
  assign tv_x_o  = tv_x_q;
  assign tv_y_o  = tv_y_q;
  assign field_o = field_q;

endmodule

// File: rtl/itu_656_encoder.sv
// itu_656_encoder
// ITU-R BT.656 525/60 byte-stream generator (Cb Y Cr Y) from 16-bit 4:2:2
// {Y,C} pixels pulled from a frame source with a request strobe.
// Ports:
//   iCLK_27, iRST_N  27 MHz byte clock, async active-low reset
//   iYCbCr, iMUTE    pixel word and mute, valid REQ_LAT clocks after oREQ
//   oREQ, oTV_X, oTV_Y, oFIELD  pixel request interface
//   oSYNC            marks the 0xFF byte of each EAV/SAV
//   oTD_DATA         BT.656 byte stream, REQ_LAT+3 clocks behind the byte counter
module itu_656_encoder
  import itu656_pkg::*;
#(
  parameter int unsigned REQ_LAT = 1,
  parameter int unsigned H_TOTAL = 1716,
  parameter int unsigned V_TOTAL = 525
) (
  input  logic        iCLK_27,
  input  logic        iRST_N,
  input  logic [15:0] iYCbCr,
  input  logic        iMUTE,
  output logic        oREQ,
  output logic [9:0]  oTV_X,
  output logic [9:0]  oTV_Y,
  output logic        oFIELD,
  output logic        oSYNC,
  output logic [7:0]  oTD_DATA
);

  if (REQ_LAT < 1 || REQ_LAT > 2) begin : g_bad_req_lat
    $error("itu_656_encoder: REQ_LAT must be 1 or 2");
  end

  // Keeps the delay line legal even when the elaboration check above fires.
  localparam int unsigned DLY = (REQ_LAT < 1) ? 1 : REQ_LAT;

  ctl_t       ctl_s1;
  ctl_t       dly_q [DLY];
  ctl_t       cap_ctl;
  logic       st2_vid_q, st2_sync_q;
  logic [1:0] st2_phase_q;
  logic [7:0] st2_fixed_q;
  logic [7:0] y_even_q, c_even_q, y_odd_q, c_odd_q;
  logic       mute_q;
  logic [7:0] byte_d, data_q;
  logic       sync_q;

  itu656_timing_gen #(
    .H_TOTAL (H_TOTAL),
    .V_TOTAL (V_TOTAL)
  ) u_timing (
    .clk_i   (iCLK_27),
    .rst_ni  (iRST_N),
    .ctl_o   (ctl_s1),
    .req_o   (oREQ),
    .tv_x_o  (oTV_X),
    .tv_y_o  (oTV_Y),
    .field_o (oFIELD)
  );

  // The slot leaving the delay line is the one whose pixel word is on iYCbCr now.
  assign cap_ctl = dly_q[DLY-1];

  always_ff @(posedge iCLK_27 or negedge iRST_N) begin
    if (!iRST_N) begin
      for (int i = 0; i < DLY; i++) dly_q[i] <= CTL_IDLE;
      st2_vid_q   <= 1'b0;
      st2_phase_q <= 2'd0;
      st2_sync_q  <= 1'b0;
      st2_fixed_q <= BLK_Y;
      y_even_q    <= BLK_Y;
      c_even_q    <= BLK_C;
      y_odd_q     <= BLK_Y;
      c_odd_q     <= BLK_C;
      mute_q      <= 1'b0;
      data_q      <= BLK_Y;
      sync_q      <= 1'b0;
    end else begin
      dly_q[0] <= ctl_s1;
      for (int i = 1; i < DLY; i++) dly_q[i] <= dly_q[i-1];
      st2_vid_q   <= cap_ctl.vid;
      st2_phase_q <= cap_ctl.phase;
      st2_sync_q  <= cap_ctl.sync;
      st2_fixed_q <= cap_ctl.fixed;
      // Mute is latched with the even word so a pair is never split.
      if (cap_ctl.cap_even) begin
        y_even_q <= clip8(iYCbCr[15:8]);
        c_even_q <= clip8(iYCbCr[7:0]);
        mute_q   <= iMUTE;
      end
      if (cap_ctl.cap_odd) begin
        y_odd_q <= clip8(iYCbCr[15:8]);
        c_odd_q <= clip8(iYCbCr[7:0]);
      end
      data_q <= byte_d;
      sync_q <= st2_sync_q;
    end
  end

  // Odd word lands on the same edge its Cr byte enters this stage, so
  // phase 2 already sees the new odd sample.
  always_comb begin
    byte_d = st2_fixed_q;
    if (st2_vid_q) begin
      case (st2_phase_q)
        2'd0:    byte_d = mute_q ? BLK_C : c_even_q;
        2'd1:    byte_d = mute_q ? BLK_Y : y_even_q;
        2'd2:    byte_d = mute_q ? BLK_C : c_odd_q;
        default: byte_d = mute_q ? BLK_Y : y_odd_q;
      endcase
    end
  end

  assign oTD_DATA = data_q;
  assign oSYNC    = sync_q;

endmodule
